booth_radix8_multiplier: RTL and testbench
==========================================

# booth_radix8_multiplier

Pipelined radix-8 Booth multiplier for two WIDTH-bit operands. Each operand is independently treated as signed or unsigned. The block returns the full 2*WIDTH-bit product with a fixed 3-cycle latency and accepts one operation per clock. It sits as a standalone arithmetic datapath block driven by a simple start/done handshake.

## Interface
- WIDTH, 16, operand width; product is 2*WIDTH bits.
- clk  in  1  single clock, all logic on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- start  in  1  one-cycle request; operands sampled on the rising edge where start=1.
- multiplicand  in  WIDTH  operand A.
- multiplier  in  WIDTH  operand B.
- sign_mode  in  2  bit1=1: A signed (two's complement), else unsigned; bit0 same for B.
- product  out  2*WIDTH  result, valid when done=1; holds until the next done.
- done  out  1  one-cycle pulse marking a valid product.
- busy  out  1  high while any operation is in flight in stages 1–2.

## Operation
- Operand extension:
  - A is extended to WIDTH+1 bits: sign-extended if sign_mode[1], zero-extended otherwise.
  - B is extended to EXT = 3*ceil((WIDTH+1)/3) bits (18 for WIDTH=16): sign-extended if sign_mode[0], zero-extended otherwise.
- 3A is precomputed as A+2A, in WIDTH+3 bits, signed.
- Booth recoding: B is split into EXT/3 digits (6 for WIDTH=16).
  - Digit i is formed from bits {b[3i+2], b[3i+1], b[3i], b[3i-1]}, with b[-1]=0.
  - Value = -4·b3 + 2·b2 + b1 + b0, giving a range of -4..+4.
- Partial product i = digit_i × A, selected from {0, A, 2A, 3A, 4A} and negated when the digit is negative.
  - Each partial product is sign-extended to 2*WIDTH and shifted left by 3i.
- product = sum of all partial products, modulo 2^(2*WIDTH).
  - This equals the exact mathematical product for every sign_mode combination, interpreted as two's complement in 2*WIDTH bits.
- Pipeline:
  - S1 registers the extended operands and 3A.
  - S2 registers the recoded partial products.
  - S3 registers the sum into product and sets done.
  - Each stage carries a valid bit.
- start is accepted every cycle regardless of busy. Back-to-back starts produce back-to-back dones in issue order.
- busy = valid_S1 | valid_S2. It is informational only.

## Timing
- start sampled at edge N → done=1 and product valid during the cycle after edge N+2 (3-cycle latency). done is low otherwise.
- Throughput: 1 operation per cycle. There is no stall and no backpressure.
- Reset (rst_n=0 at a rising edge):
  - All valid bits, done, and busy are cleared to 0; product is cleared to 0.
  - In-flight operations are discarded and never produce done.
  - start is ignored while rst_n=0.
- Reset mid-operation: the first start after reset release is processed normally; there are no stale dones.
- Operation with no start: valid bits drain; done stays 0; product keeps its last value.
- start=1 on consecutive cycles with different sign_mode: each operation uses its own sampled sign_mode.

## Structure
- Shared package booth_pkg:
  - default WIDTH;
  - the EXT/digit-count derivation as localparams or functions;
  - the Booth digit encoding (neg flag plus magnitude select: ZERO, X1, X2, X3, X4).
- One sub-module, booth_r8_encoder: 4-bit group in → neg, magnitude select out. The multiplier instantiates it EXT/3 times.
- The partial-product mux and adder tree stay inline in the top module.

## Test plan
- 10×10, mode 11 → product 100, done exactly 3 cycles after start.
- 32767×1 and -32768×1, mode 11, issued back-to-back → 32767, then -32768 (0xFFFF8000), in order on consecutive cycles.
- 0xFFFF×0xFFFF in every mode:
  - 00 → 0xFFFE0001;
  - 11 → 1;
  - 10 → 0xFFFF0001;
  - 01 → 0xFFFF0001.
- Burst of 50 random signed pairs, start held every cycle → 50 dones, in order, each matching the reference product; busy high throughout the burst.
- Assert rst_n=0 one cycle after a start → no done; outputs are 0 on the next edge; a subsequent 3×(-5) mode 11 → -15.
- Idle with start=0 for 10 cycles after a result → done stays 0 and product is unchanged.

Source files
------------

// File: rtl/booth_pkg.sv
// rtl/booth_pkg.sv - shared widths and Booth radix-8 digit encoding
package booth_pkg;

  localparam int BOOTH_DEFAULT_WIDTH = 16;

  // Multiplier extended to a whole number of 3-bit groups covering WIDTH+1 bits.
  function automatic int booth_ext_width(input int width);
    return 3 * ((width + 3) / 3);
  endfunction

  function automatic int booth_num_digits(input int width);
    return booth_ext_width(width) / 3;
  endfunction

  typedef enum logic [2:0] {
    MAG_ZERO = 3'd0,
    MAG_X1   = 3'd1,
    MAG_X2   = 3'd2,
    MAG_X3   = 3'd3,
    MAG_X4   = 3'd4
  } booth_mag_e;

  typedef struct packed {
    logic       neg;
    booth_mag_e mag;
  } booth_digit_t;

endpackage

// File: rtl/booth_r8_encoder.sv
// rtl/booth_r8_encoder.sv - radix-8 Booth recoder for one overlapping 4-bit group
module booth_r8_encoder
  import booth_pkg::*;
(
  input  logic [3:0]   i_group,
  output booth_digit_t o_digit
);

  // Group is {b[3i+2], b[3i+1], b[3i], b[3i-1]}; value = -4*b3 + 2*b2 + b1 + b0.
  always_comb begin
    o_digit.neg = 1'b0;
    o_digit.mag = MAG_ZERO;
    case (i_group)
      4'b0000: begin o_digit.neg = 1'b0; o_digit.mag = MAG_ZERO; end
      4'b0001: begin o_digit.neg = 1'b0; o_digit.mag = MAG_X1;   end
      4'b0010: begin o_digit.neg = 1'b0; o_digit.mag = MAG_X1;   end
      4'b0011: begin o_digit.neg = 1'b0; o_digit.mag = MAG_X2;   end
      4'b0100: begin o_digit.neg = 1'b0; o_digit.mag = MAG_X2;   end
      4'b0101: begin o_digit.neg = 1'b0; o_digit.mag = MAG_X3;   end
      4'b0110: begin o_digit.neg = 1'b0; o_digit.mag = MAG_X3;   end
      4'b0111: begin o_digit.neg = 1'b0; o_digit.mag = MAG_X4;   end
      4'b1000: begin o_digit.neg = 1'b1; o_digit.mag = MAG_X4;   end
      4'b1001: begin o_digit.neg = 1'b1; o_digit.mag = MAG_X3;   end
      4'b1010: begin o_digit.neg = 1'b1; o_digit.mag = MAG_X3;   end
      4'b1011: begin o_digit.neg = 1'b1; o_digit.mag = MAG_X2;   end
      4'b1100: begin o_digit.neg = 1'b1; o_digit.mag = MAG_X2;   end
      4'b1101: begin o_digit.neg = 1'b1; o_digit.mag = MAG_X1;   end
      4'b1110: begin o_digit.neg = 1'b1; o_digit.mag = MAG_X1;   end
      default: begin o_digit.neg = 1'b0; o_digit.mag = MAG_ZERO; end
    endcase
  end

endmodule

// File: rtl/booth_radix8_multiplier.sv
// rtl/booth_radix8_multiplier.sv - 3-stage pipelined radix-8 Booth multiplier, signed/unsigned operands
module booth_radix8_multiplier
  import booth_pkg::*;
#(
  parameter int WIDTH = BOOTH_DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  input  logic [1:0]         sign_mode,
  output logic [2*WIDTH-1:0] product,
  output logic               done,
  output logic               busy
);

  localparam int EXT  = booth_ext_width(WIDTH);
  localparam int NDIG = booth_num_digits(WIDTH);
  localparam int PW   = 2 * WIDTH;
  localparam int AW   = WIDTH + 3;

  logic [WIDTH:0] w_a_ext;
  logic [EXT-1:0] w_b_ext;
  logic [AW-1:0]  w_a3;

  assign w_a_ext = {sign_mode[1] & multiplicand[WIDTH-1], multiplicand};
  assign w_b_ext = {{(EXT-WIDTH){sign_mode[0] & multiplier[WIDTH-1]}}, multiplier};
  assign w_a3    = {{2{w_a_ext[WIDTH]}}, w_a_ext} + {w_a_ext[WIDTH], w_a_ext, 1'b0};

  logic           r_s1_valid;
  logic [WIDTH:0] r_s1_a;
  logic [AW-1:0]  r_s1_a3;
  logic [EXT-1:0] r_s1_b;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
    end else begin
      r_s1_valid <= start;
      if (start) begin
        r_s1_a  <= w_a_ext;
        r_s1_a3 <= w_a3;
        r_s1_b  <= w_b_ext;
      end
    end
  end

  logic [EXT:0]  w_b_pad;
  booth_digit_t  w_digit [NDIG];
  logic [AW-1:0] w_a1;
  logic [AW-1:0] w_a2;
  logic [AW-1:0] w_a4;
  logic [AW-1:0] w_mag   [NDIG];
  logic [AW-1:0] w_sel   [NDIG];
  logic [PW-1:0] w_pp    [NDIG];

  // Appended zero supplies b[-1] for the lowest digit.
  assign w_b_pad = {r_s1_b, 1'b0};
  assign w_a1    = {{2{r_s1_a[WIDTH]}}, r_s1_a};
  assign w_a2    = {r_s1_a[WIDTH], r_s1_a, 1'b0};
  assign w_a4    = {r_s1_a, 2'b00};

  for (genvar g = 0; g < NDIG; g++) begin : g_enc
    booth_r8_encoder u_enc (
      .i_group (w_b_pad[3*g+3 -: 4]),
      .o_digit (w_digit[g])
    );
  end

  always_comb begin
    for (int i = 0; i < NDIG; i++) begin
      w_mag[i] = '0;
      w_sel[i] = '0;
      w_pp[i]  = '0;
    end
    for (int i = 0; i < NDIG; i++) begin
      case (w_digit[i].mag)
        MAG_X1:  w_mag[i] = w_a1;
        MAG_X2:  w_mag[i] = w_a2;
        MAG_X3:  w_mag[i] = r_s1_a3;
        MAG_X4:  w_mag[i] = w_a4;
        default: w_mag[i] = '0;
      endcase
      w_sel[i] = w_digit[i].neg ? (~w_mag[i] + AW'(1)) : w_mag[i];
      w_pp[i]  = {{(PW-AW){w_sel[i][AW-1]}}, w_sel[i]} << (3 * i);
    end
  end

  logic          r_s2_valid;
  logic [PW-1:0] r_s2_pp [NDIG];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s2_valid <= 1'b0;
    end else begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        for (int i = 0; i < NDIG; i++) begin
          r_s2_pp[i] <= w_pp[i];
        end
      end
    end
  end

  // Modulo-2^PW sum; every partial product is already sign-extended to PW.
  logic [PW-1:0] w_sum;

  always_comb begin
    w_sum = '0;
    for (int i = 0; i < NDIG; i++) begin
      w_sum = w_sum + r_s2_pp[i];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      product <= '0;
      done    <= 1'b0;
    end else begin
      done <= r_s2_valid;
      if (r_s2_valid) begin
        product <= w_sum;
      end
    end
  end

  assign busy = r_s1_valid | r_s2_valid;

endmodule

// File: tb/tb_booth_radix8_multiplier.sv
// tb/tb_booth_radix8_multiplier.sv - scoreboard bench for booth_radix8_multiplier
module tb_booth_radix8_multiplier;

  localparam int W = 16;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           start;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic [1:0]     sm;
  logic [2*W-1:0] product;
  logic           done;
  logic           busy;

  typedef struct {
    logic [2*W-1:0] exp;
    int             cyc;
  } sb_t;

  sb_t            sb_q[$];
  int             n_vec = 0;
  int             n_err = 0;
  int             cyc = 0;
  logic [2*W-1:0] last_exp = '0;

  booth_radix8_multiplier #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .multiplicand (a),
    .multiplier   (b),
    .sign_mode    (sm),
    .product      (product),
    .done         (done),
    .busy         (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y,
                                             input logic [1:0] m);
    longint sx, sy, p;
    sx = m[1] ? longint'($signed(x)) : longint'(x);
    sy = m[0] ? longint'($signed(y)) : longint'(y);
    p  = sx * sy;
    return p[2*W-1:0];
  endfunction

  always @(negedge clk) begin
    sb_t e;
    if (done) begin
      n_vec++;
      if (sb_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_done product=%h required=no_done", product);
      end else begin
        e = sb_q.pop_front();
        if (product !== e.exp) begin
          n_err++;
          $display("FAIL product got=%h required=%h", product, e.exp);
        end
        n_vec++;
        if (cyc != e.cyc + 3) begin
          n_err++;
          $display("FAIL latency got=%0d required=3", cyc - e.cyc);
        end
        last_exp = e.exp;
      end
    end
  end

  task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y, input logic [1:0] m,
                       input logic [2*W-1:0] exp, input bit track);
    @(negedge clk);
    start = 1'b1;
    a     = x;
    b     = y;
    sm    = m;
    if (track) sb_q.push_back('{exp: exp, cyc: cyc});
  endtask

  task automatic idle();
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_drain();
    int k;
    k = 0;
    while (sb_q.size() != 0 && k < 20) begin
      @(negedge clk);
      k++;
    end
    @(negedge clk);
    n_vec++;
    if (sb_q.size() != 0) begin
      n_err++;
      $display("FAIL drain_timeout pending=%0d required=0", sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    a = '0;
    b = '0;
    sm = 2'b00;
    repeat (3) @(negedge clk);
    n_vec += 3;
    if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got=%b required=0", done); end
    if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b required=0", busy); end
    if (product !== '0) begin n_err++; $display("FAIL reset_product got=%h required=0", product); end
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    issue(16'd10, 16'd10, 2'b11, 32'd100, 1'b1);
    idle();
    wait_drain();
  endtask

  task automatic test_back_to_back();
    issue(16'd32767, 16'd1, 2'b11, 32'h0000_7FFF, 1'b1);
    issue(16'h8000, 16'd1, 2'b11, 32'hFFFF_8000, 1'b1);
    idle();
    wait_drain();
  endtask

  task automatic test_modes();
    issue(16'hFFFF, 16'hFFFF, 2'b00, 32'hFFFE_0001, 1'b1);
    issue(16'hFFFF, 16'hFFFF, 2'b11, 32'h0000_0001, 1'b1);
    issue(16'hFFFF, 16'hFFFF, 2'b10, 32'hFFFF_0001, 1'b1);
    issue(16'hFFFF, 16'hFFFF, 2'b01, 32'hFFFF_0001, 1'b1);
    idle();
    wait_drain();
  endtask

  task automatic test_burst();
    logic [W-1:0] x, y;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (i > 0) begin
        n_vec++;
        if (busy !== 1'b1) begin n_err++; $display("FAIL burst_busy idx=%0d got=%b required=1", i, busy); end
      end
      x = W'($urandom());
      y = W'($urandom());
      start = 1'b1;
      a = x;
      b = y;
      sm = 2'b11;
      sb_q.push_back('{exp: ref_mul(x, y, 2'b11), cyc: cyc});
    end
    @(negedge clk);
    n_vec++;
    if (busy !== 1'b1) begin n_err++; $display("FAIL burst_busy_tail got=%b required=1", busy); end
    start = 1'b0;
    wait_drain();
  endtask

  task automatic test_reset_mid();
    issue(16'd1234, 16'd5678, 2'b11, '0, 1'b0);
    @(negedge clk);
    start = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    n_vec += 3;
    if (done !== 1'b0) begin n_err++; $display("FAIL midrst_done got=%b required=0", done); end
    if (busy !== 1'b0) begin n_err++; $display("FAIL midrst_busy got=%b required=0", busy); end
    if (product !== '0) begin n_err++; $display("FAIL midrst_product got=%h required=0", product); end
    start = 1'b1;
    a = 16'd7;
    b = 16'd9;
    repeat (2) @(negedge clk);
    start = 1'b0;
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    issue(16'd3, 16'hFFFB, 2'b11, 32'hFFFF_FFF1, 1'b1);
    idle();
    wait_drain();
  endtask

  task automatic test_idle();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_vec += 2;
      if (done !== 1'b0) begin n_err++; $display("FAIL idle_done cyc=%0d got=%b required=0", i, done); end
      if (product !== last_exp) begin
        n_err++;
        $display("FAIL idle_product cyc=%0d got=%h required=%h", i, product, last_exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_modes();
    test_burst();
    test_reset_mid();
    test_idle();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog elapsed required=finish");
    $fatal(1, "watchdog");
  end

endmodule
